// File: rtl/bus_initiator_pkg.sv
// +----------------------------------------------------------------------------+
// | bus_pkg : shared types and constants for the second memory-bus initiator   |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package bus_pkg;

    localparam int BUS_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RSP  = 2'd2
    } bus_state_e;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  wrmask;
        logic [31:0] data;
    } bus_cmd_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } bus_rsp_t;

endpackage

`default_nettype wire

// File: rtl/bus_initiator_if.sv
// +----------------------------------------------------------------------------+
// | bus_initiator_if : command, response and memory-bus signals of the         |
// |                    initiator; master = initiator, slave = its environment  |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

interface bus_initiator_if;

    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_wr;
    logic [31:0] i_cmd_addr;
    logic [3:0]  i_cmd_wrmask;
    logic [31:0] i_cmd_data;

    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_data;
    logic        o_rsp_err;

    logic        o_bus_rd;
    logic        o_bus_wr;
    logic [31:0] o_bus_addr;
    logic [3:0]  o_bus_wrmask;
    logic [31:0] o_bus_data;
    logic        i_bus_rd_valid;
    logic        i_bus_wr_valid;
    logic [31:0] i_bus_data;

    modport master (
        input  i_cmd_valid, i_cmd_wr, i_cmd_addr, i_cmd_wrmask, i_cmd_data,
        input  i_rsp_ready,
        input  i_bus_rd_valid, i_bus_wr_valid, i_bus_data,
        output o_cmd_ready,
        output o_rsp_valid, o_rsp_data, o_rsp_err,
        output o_bus_rd, o_bus_wr, o_bus_addr, o_bus_wrmask, o_bus_data
    );

    modport slave (
        output i_cmd_valid, i_cmd_wr, i_cmd_addr, i_cmd_wrmask, i_cmd_data,
        output i_rsp_ready,
        output i_bus_rd_valid, i_bus_wr_valid, i_bus_data,
        input  o_cmd_ready,
        input  o_rsp_valid, o_rsp_data, o_rsp_err,
        input  o_bus_rd, o_bus_wr, o_bus_addr, o_bus_wrmask, o_bus_data
    );

endinterface

`default_nettype wire

// File: rtl/bus_timeout_ctr.sv
// +----------------------------------------------------------------------------+
// | bus_timeout_ctr : counts outstanding-request cycles and flags expiry once  |
// |                   the count reaches TIMEOUT-1                              |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module bus_timeout_ctr
    import bus_pkg::*;
#(
    parameter int TIMEOUT = BUS_TIMEOUT_DEFAULT,
    parameter int CNT_W   = 8
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expired
);

    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;

    // Saturates at the limit so a held enable never wraps back to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (i_clear) begin
            count_q <= '0;
        end else if (i_enable && !o_expired) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign o_expired = (count_q == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/bus_initiator.sv
// +----------------------------------------------------------------------------+
// | bus_initiator : single-outstanding memory-bus initiator with alignment     |
// |                 checking and a request timeout                             |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module bus_initiator
    import bus_pkg::*;
#(
    parameter int TIMEOUT = BUS_TIMEOUT_DEFAULT,
    parameter int CNT_W   = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    bus_initiator_if.master bif
);

    bus_state_e state_q;
    bus_cmd_t   req_q;
    bus_rsp_t   rsp_q;
    logic       cmd_ready_q;
    logic       rsp_valid_q;
    logic       bus_rd_q;
    logic       bus_wr_q;

    logic       w_expired;
    logic       w_bus_done;

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (state_q != BUS),
        .i_enable  (state_q == BUS),
        .o_expired (w_expired)
    );

    // The opposite-type completion is deliberately ignored
    assign w_bus_done = req_q.wr ? bif.i_bus_wr_valid : bif.i_bus_rd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            rsp_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            bus_rd_q    <= 1'b0;
            bus_wr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bif.i_cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        if (bif.i_cmd_addr[1:0] != 2'b00) begin
                            state_q     <= RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_q       <= '{data: 32'h0, err: 1'b1};
                        end else begin
                            state_q      <= BUS;
                            bus_rd_q     <= !bif.i_cmd_wr;
                            bus_wr_q     <= bif.i_cmd_wr;
                            req_q.wr     <= bif.i_cmd_wr;
                            req_q.addr   <= bif.i_cmd_addr;
                            req_q.wrmask <= bif.i_cmd_wr ? bif.i_cmd_wrmask : 4'h0;
                            req_q.data   <= bif.i_cmd_wr ? bif.i_cmd_data : 32'h0;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end

                BUS: begin
                    // Completion takes priority over a coincident timeout
                    if (w_bus_done) begin
                        state_q     <= RSP;
                        bus_rd_q    <= 1'b0;
                        bus_wr_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_q       <= '{data: (req_q.wr ? 32'h0 : bif.i_bus_data), err: 1'b0};
                    end else if (w_expired) begin
                        state_q     <= RSP;
                        bus_rd_q    <= 1'b0;
                        bus_wr_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_q       <= '{data: 32'h0, err: 1'b1};
                    end
                end

                RSP: begin
                    if (bif.i_rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_q       <= '0;
                        cmd_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    bus_rd_q    <= 1'b0;
                    bus_wr_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bif.o_cmd_ready  = cmd_ready_q;
    assign bif.o_rsp_valid  = rsp_valid_q;
    assign bif.o_rsp_data   = rsp_q.data;
    assign bif.o_rsp_err    = rsp_q.err;
    assign bif.o_bus_rd     = bus_rd_q;
    assign bif.o_bus_wr     = bus_wr_q;
    assign bif.o_bus_addr   = req_q.addr;
    assign bif.o_bus_wrmask = req_q.wrmask;
    assign bif.o_bus_data   = req_q.data;

endmodule

`default_nettype wire

// File: tb/tb_bus_initiator.sv
// +----------------------------------------------------------------------------+
// | tb_bus_initiator : directed self-checking bench for bus_initiator          |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bus_initiator;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_initiator_if bif ();

    bus_initiator #(
        .TIMEOUT (8),
        .CNT_W   (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bif   (bif)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic stray_rd = 1'b0;
    logic wr_en    = 1'b0;
    int   wr_cnt   = 0;

    // Responder: ram answers reads in the request cycle, writer answers in the third
    always_comb begin
        bif.i_bus_rd_valid = stray_rd;
        bif.i_bus_data     = 32'h0;
        if (bif.o_bus_rd) begin
            case (bif.o_bus_addr)
                32'h0000_0010: begin bif.i_bus_rd_valid = 1'b1; bif.i_bus_data = 32'hDEAD_BEEF; end
                32'h0000_0040: begin bif.i_bus_rd_valid = 1'b1; bif.i_bus_data = 32'hA5A5_0001; end
                default: ;
            endcase
        end
        bif.i_bus_wr_valid = wr_en && bif.o_bus_wr && (wr_cnt == 2);
    end

    always @(posedge clk) wr_cnt <= bif.o_bus_wr ? wr_cnt + 1 : 0;

    int          rd_hi = 0, wr_hi = 0, rsp_hs = 0, unstable = 0, both_hi = 0;
    logic [31:0] exp_addr = 32'h0, exp_data = 32'h0;
    logic [3:0]  exp_mask = 4'h0;

    always @(negedge clk) begin
        if (bif.o_bus_rd) rd_hi++;
        if (bif.o_bus_wr) begin
            wr_hi++;
            if (bif.o_bus_addr != exp_addr || bif.o_bus_wrmask != exp_mask || bif.o_bus_data != exp_data)
                unstable++;
        end
        if (bif.o_bus_rd && bif.o_bus_wr) both_hi++;
        if (bif.o_rsp_valid && bif.i_rsp_ready) rsp_hs++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns one time unit after the accepting edge
    task automatic send_cmd(input logic wr, input logic [31:0] addr,
                            input logic [3:0] mask, input logic [31:0] data);
        bit done;
        done             = 1'b0;
        bif.i_cmd_valid  = 1'b1;
        bif.i_cmd_wr     = wr;
        bif.i_cmd_addr   = addr;
        bif.i_cmd_wrmask = mask;
        bif.i_cmd_data   = data;
        for (int n = 0; n < 50 && !done; n++) begin
            if (bif.o_cmd_ready) done = 1'b1;
            step();
        end
        bif.i_cmd_valid = 1'b0;
        check("cmd_accept", 32'(done), 32'd1);
    endtask

    int base_r, base_w, base_hs, bp_bad;

    initial begin
        bif.i_cmd_valid  = 1'b0;
        bif.i_cmd_wr     = 1'b0;
        bif.i_cmd_addr   = 32'h0;
        bif.i_cmd_wrmask = 4'h0;
        bif.i_cmd_data   = 32'h0;
        bif.i_rsp_ready  = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(bif.o_cmd_ready), 32'd0);
        check("rst_ctl", {28'h0, bif.o_rsp_valid, bif.o_rsp_err, bif.o_bus_rd, bif.o_bus_wr}, 32'h0);
        check("rst_rsp_data", bif.o_rsp_data, 32'h0);
        check("rst_bus_addr_data", bif.o_bus_addr | bif.o_bus_data | 32'(bif.o_bus_wrmask), 32'h0);
        rst_n = 1'b1;
        step();
        check("idle_cmd_ready", 32'(bif.o_cmd_ready), 32'd1);

        // Aligned read, single-cycle ram
        base_r = rd_hi;
        send_cmd(1'b0, 32'h10, 4'h0, 32'h0);
        check("rd_req", {31'h0, bif.o_bus_rd}, 32'd1);
        check("rd_addr", bif.o_bus_addr, 32'h10);
        step();
        check("rd_rsp_valid", 32'(bif.o_rsp_valid), 32'd1);
        check("rd_rsp_data", bif.o_rsp_data, 32'hDEAD_BEEF);
        check("rd_rsp_err", 32'(bif.o_rsp_err), 32'd0);
        check("rd_req_drop", 32'(bif.o_bus_rd), 32'd0);
        step();
        check("rd_rsp_done", 32'(bif.o_rsp_valid), 32'd0);
        check("rd_req_cycles", 32'(rd_hi - base_r), 32'd1);

        // Write with a 3-cycle responder
        wr_en    = 1'b1;
        exp_addr = 32'h20;
        exp_mask = 4'b0011;
        exp_data = 32'h1234_5678;
        base_w   = wr_hi;
        send_cmd(1'b1, 32'h20, 4'b0011, 32'h1234_5678);
        check("wr_req", {30'h0, bif.o_bus_rd, bif.o_bus_wr}, 32'd1);
        check("wr_mask", 32'(bif.o_bus_wrmask), 32'h3);
        check("wr_data", bif.o_bus_data, 32'h1234_5678);
        step();
        step();
        check("wr_req_held", {30'h0, bif.o_bus_wr, bif.o_rsp_valid}, 32'h2);
        step();
        check("wr_req_drop", 32'(bif.o_bus_wr), 32'd0);
        check("wr_rsp_valid", 32'(bif.o_rsp_valid), 32'd1);
        check("wr_rsp_data", bif.o_rsp_data, 32'h0);
        check("wr_rsp_err", 32'(bif.o_rsp_err), 32'd0);
        step();
        check("wr_req_cycles", 32'(wr_hi - base_w), 32'd3);
        wr_en = 1'b0;

        // Misaligned read never reaches the bus
        base_r = rd_hi;
        send_cmd(1'b0, 32'h13, 4'h0, 32'h0);
        check("mis_rsp_valid", 32'(bif.o_rsp_valid), 32'd1);
        check("mis_rsp_err", 32'(bif.o_rsp_err), 32'd1);
        check("mis_rsp_data", bif.o_rsp_data, 32'h0);
        step();
        step();
        check("mis_no_req", 32'(rd_hi - base_r), 32'd0);

        // Unmapped read times out after 8 cycles
        base_r  = rd_hi;
        base_hs = rsp_hs;
        send_cmd(1'b0, 32'h100, 4'hF, 32'hFFFF_FFFF);
        check("to_rd_mask", 32'(bif.o_bus_wrmask), 32'h0);
        check("to_rd_data", bif.o_bus_data, 32'h0);
        repeat (7) step();
        check("to_req_held", {30'h0, bif.o_bus_rd, bif.o_rsp_valid}, 32'h2);
        step();
        check("to_req_drop", 32'(bif.o_bus_rd), 32'd0);
        check("to_rsp_valid", 32'(bif.o_rsp_valid), 32'd1);
        check("to_rsp_err", 32'(bif.o_rsp_err), 32'd1);
        check("to_rsp_data", bif.o_rsp_data, 32'h0);
        step();
        check("to_req_cycles", 32'(rd_hi - base_r), 32'd8);
        repeat (5) step();
        stray_rd = 1'b1;
        step();
        stray_rd = 1'b0;
        repeat (3) step();
        check("stray_no_rsp", 32'(rsp_hs - base_hs), 32'd1);
        check("stray_rsp_valid", 32'(bif.o_rsp_valid), 32'd0);

        // Response backpressure with a second command pending
        bif.i_rsp_ready = 1'b0;
        send_cmd(1'b0, 32'h40, 4'h0, 32'h0);
        bif.i_cmd_valid  = 1'b1;
        bif.i_cmd_wr     = 1'b0;
        bif.i_cmd_addr   = 32'h10;
        bp_bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!bif.o_rsp_valid || bif.o_rsp_data != 32'hA5A5_0001 || bif.o_cmd_ready || bif.o_bus_rd)
                bp_bad++;
        end
        check("bp_hold", 32'(bp_bad), 32'd0);
        bif.i_rsp_ready = 1'b1;
        step();
        check("bp_released", {30'h0, bif.o_rsp_valid, bif.o_cmd_ready}, 32'h1);
        step();
        bif.i_cmd_valid = 1'b0;
        check("bp_second_req", {31'h0, bif.o_bus_rd}, 32'd1);
        check("bp_second_addr", bif.o_bus_addr, 32'h10);
        step();
        check("bp_second_rsp", bif.o_rsp_data, 32'hDEAD_BEEF);
        step();

        // Reset in the middle of a write
        exp_addr = 32'h30;
        exp_mask = 4'hF;
        exp_data = 32'hCAFE_F00D;
        send_cmd(1'b1, 32'h30, 4'hF, 32'hCAFE_F00D);
        check("rst_mid_req", 32'(bif.o_bus_wr), 32'd1);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctl", {29'h0, bif.o_bus_wr, bif.o_rsp_valid, bif.o_cmd_ready}, 32'h0);
        check("rst_mid_addr", bif.o_bus_addr, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rst_rel_ready", {30'h0, bif.o_cmd_ready, bif.o_bus_wr}, 32'h2);
        send_cmd(1'b0, 32'h10, 4'h0, 32'h0);
        check("rst_rd_req", 32'(bif.o_bus_rd), 32'd1);
        step();
        check("rst_rd_rsp", {bif.o_rsp_data[30:0], bif.o_rsp_valid}, {31'h5EAD_BEEF, 1'b1});
        check("rst_rd_err", 32'(bif.o_rsp_err), 32'd0);
        step();

        check("never_rd_and_wr", 32'(both_hi), 32'd0);
        check("wr_stable", 32'(unstable), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bus_initiator.md
Name: bus_initiator

Overview:
- Second initiator for the SoC memory bus; it drives the same rd/wr/addr/wrmask/data request signals the CPU drives and consumes the OR-combined rd_valid/wr_valid/data returned by responders (ram, timer, gpi, gpo, gpio).
- A client (debug bridge, DMA engine, test harness) issues single-word commands through a valid/ready command port and receives one response per command on a valid/ready response port.
- Adds alignment checking and a bus timeout, so a missing responder cannot hang the client.

Parameters:
- TIMEOUT, 255: cycles a request may stay outstanding before it is aborted with an error (must be at least 2).
- CNT_W, 8: width of the timeout counter; TIMEOUT must be less than 2^CNT_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  command accepted when valid&ready
- i_cmd_wr  in  1  1=write, 0=read
- i_cmd_addr  in  32  byte address, word aligned
- i_cmd_wrmask  in  4  byte enables for write
- i_cmd_data  in  32  write data
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  response consumed when valid&ready
- o_rsp_data  out  32  read data (0 for writes and errors)
- o_rsp_err  out  1  1=misaligned or timeout
- o_bus_rd  out  1  bus read request
- o_bus_wr  out  1  bus write request
- o_bus_addr  out  32  bus address
- o_bus_wrmask  out  4  bus byte enables
- o_bus_data  out  32  bus write data
- i_bus_rd_valid  in  1  read completion (OR of responders)
- i_bus_wr_valid  in  1  write completion (OR of responders)
- i_bus_data  in  32  read data (OR of responders)

Behaviour:
- Reset (async assert, sync release): state IDLE. o_cmd_ready=0 during reset, 1 in IDLE afterwards. o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0, o_bus_rd=0, o_bus_wr=0, o_bus_addr=0, o_bus_wrmask=0, o_bus_data=0, counter=0.
- All outputs are registered. o_cmd_ready = (state==IDLE).
- IDLE: on valid&ready, latch the command.
  - If addr[1:0]!=0: go to RSP with err=1, data=0; no bus activity.
  - Otherwise: go to BUS and, on the next cycle, assert o_bus_rd or o_bus_wr (never both). For reads, o_bus_wrmask=0 and o_bus_data=0.
- BUS: request signals and address/mask/data stay stable until completion.
  - Only the valid matching the request type counts: i_bus_rd_valid for a read, i_bus_wr_valid for a write. The other valid is ignored.
  - When the matching valid is sampled high: capture i_bus_data (reads only; writes return 0), drop o_bus_rd/o_bus_wr to 0 on the next edge, go to RSP with err=0.
  - The counter increments each BUS cycle. If the counter reaches TIMEOUT-1 with no valid: drop the request, go to RSP with err=1, data=0.
  - If valid arrives in the same cycle the counter hits its limit, valid wins (err=0).
- RSP: o_rsp_valid=1 and data/err held stable until i_rsp_ready. On handshake, o_rsp_valid=0, return to IDLE, counter cleared.
- Latency: command accepted at edge 0; request visible at cycle 1; valid sampled at cycle k gives o_rsp_valid at k+1. Minimum command-to-response is 2 cycles with a 1-cycle responder.
- Back-to-back commands: at least one idle bus cycle separates successive requests; there is no pipelining and at most one outstanding request.
- Responder valid pulses while not in BUS are ignored.
- Reset asserted mid-transaction: all outputs return to reset values immediately; the in-flight command and response are discarded.

Decomposition:
- Package bus_pkg holds:
  - state enum (IDLE, BUS, RSP);
  - packed struct bus_cmd_t (wr, addr, wrmask, data);
  - packed struct bus_rsp_t (data, err);
  - constant BUS_TIMEOUT_DEFAULT=255.
- One sub-module, bus_timeout_ctr, provides clear/enable inputs and an expired output parameterised by TIMEOUT/CNT_W. Everything else stays in bus_initiator.

Test Plan:
- Read with a 1-cycle ram model where addr 0x0000_0010 holds 0xDEAD_BEEF: o_bus_rd high exactly 1 cycle with o_bus_addr=0x10; response data=0xDEAD_BEEF, err=0, 2 cycles after accept.
- Write addr 0x20, data 0x1234_5678, wrmask 0b0011, with a responder asserting wr_valid after 3 cycles: o_bus_wr held 3 cycles with stable addr/mask/data; response data=0, err=0.
- Misaligned read at addr 0x0000_0013: no o_bus_rd ever asserted; response err=1, data=0, 1 cycle after accept.
- Read to an unmapped address with no responder, TIMEOUT=8: o_bus_rd high for exactly 8 cycles then low; response err=1, data=0. A stray i_bus_rd_valid 5 cycles later produces no second response.
- Response backpressure: i_rsp_ready low for 10 cycles after a read returning 0xA5A5_0001: o_rsp_valid and data held; o_cmd_ready stays 0 and a second pending command is not accepted until the handshake.
- Reset mid-BUS (rst_n low 2 cycles during a write): o_bus_wr, o_rsp_valid and o_cmd_ready go 0 immediately. After release, o_cmd_ready=1 and a fresh read completes normally.
